ps2_mouse_init: RTL and testbench

Power-up and recovery sequencer for the PS/2 mouse port. It drives the host-to-device transmitter with the standard initialization command sequence and checks each device response from the mouse receiver. Once the mouse is streaming, it opens a gate that lets received bytes reach the packet assembler. It sits between the debounced restart button, the PS/2 TX/RX pair and the mouse packet/XY path.

---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_ms_timer.sv | 34 +++
 rtl/ps2_mouse_init.sv | 245 ++++++++++++++++++++++++
 tb/tb_ps2_mouse_init.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse definitions: command/response bytes, sequencer state codes
// and the timer width helper used by the init sequencer and its timer.
package ps2_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_ERR      = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_ID       = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_WAIT_TX  = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_STREAM   = 3'd4,
        ST_FAIL     = 3'd5
    } ps2_state_e;

    // Bits needed to hold the longest millisecond window in clock cycles.
    function automatic int timer_width(input int clk_hz, input int max_ms);
        return $clog2(clk_hz / 1000 * max_ms + 1);
    endfunction

endpackage

// File: rtl/ps2_ms_timer.sv
// Loadable down-counter sized from the clock rate and the longest window;
// expired is high while the count sits at zero.
module ps2_ms_timer
    import ps2_pkg::*;
#(
    parameter int  CLK_HZ = 100_000_000,
    parameter int  MAX_MS = 750,
    localparam int W      = timer_width(CLK_HZ, MAX_MS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count_r;

    // Count register: load wins, otherwise count down and stop at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {W{1'b0}}) begin
            count_r <= count_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == {W{1'b0}});

endmodule

// File: rtl/ps2_mouse_init.sv
// PS/2 mouse power-up/recovery sequencer: walks the init command script,
// checks device replies, retries on failure and gates streaming data.
module ps2_mouse_init
    import ps2_pkg::*;
#(
    parameter int         CLK_HZ         = 100_000_000,
    parameter int         PWRUP_MS       = 600,
    parameter int         TIMEOUT_MS     = 25,
    parameter int         BAT_TIMEOUT_MS = 750,
    parameter int         MAX_RETRY      = 3,
    parameter logic [7:0] SAMPLE_RATE    = 8'd100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic       stream_en,
    output logic       init_done,
    output logic       init_error,
    output logic [1:0] retry_cnt,
    output logic [2:0] led_state
);

    localparam int              TW          = timer_width(CLK_HZ, BAT_TIMEOUT_MS);
    localparam logic [TW-1:0]   PWRUP_CYC   = TW'(CLK_HZ / 1000 * PWRUP_MS);
    localparam logic [TW-1:0]   TIMEOUT_CYC = TW'(CLK_HZ / 1000 * TIMEOUT_MS);
    localparam logic [TW-1:0]   BAT_CYC     = TW'(CLK_HZ / 1000 * BAT_TIMEOUT_MS);
    localparam logic [1:0]      MAX_RETRY_C = 2'(MAX_RETRY);

    ps2_state_e    state_r, state_next;
    logic [2:0]    step_r, step_next;
    logic [1:0]    idx_r, idx_next;
    logic [1:0]    resend_r, resend_next;
    logic [1:0]    retry_r, retry_next;
    logic          hp_r, hp_next;
    logic          armed_r;
    logic          fail_s, load_s, expired_s;
    logic [TW-1:0] load_val_s;
    logic [7:0]    cmd_s, exp_s;
    logic [1:0]    rsp_len_s;
    logic          tx_start_r, stream_r, done_r, err_r;
    logic [7:0]    tx_data_r;
    logic [2:0]    led_r;

    ps2_ms_timer #(
        .CLK_HZ (CLK_HZ),
        .MAX_MS (BAT_TIMEOUT_MS)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_val (load_val_s),
        .expired  (expired_s)
    );

    // Script ROM: command byte and reply count per step.
    always_comb begin
        case (step_r)
            3'd0:    begin cmd_s = CMD_RESET;    rsp_len_s = 2'd3; end
            3'd1:    begin cmd_s = CMD_SET_RATE; rsp_len_s = 2'd1; end
            3'd2:    begin cmd_s = SAMPLE_RATE;  rsp_len_s = 2'd1; end
            3'd3:    begin cmd_s = CMD_ENABLE;   rsp_len_s = 2'd1; end
            default: begin cmd_s = 8'h00;        rsp_len_s = 2'd0; end
        endcase
    end

    // Expected reply ROM: only the reset step has more than an ACK.
    always_comb begin
        case ({step_r, idx_r})
            5'b000_00: exp_s = RSP_ACK;
            5'b000_01: exp_s = RSP_BAT_OK;
            5'b000_10: exp_s = RSP_ID;
            default:   exp_s = RSP_ACK;
        endcase
    end

    // Next-state logic; failure and restart overrides are applied last.
    always_comb begin
        state_next  = state_r;
        step_next   = step_r;
        idx_next    = idx_r;
        resend_next = resend_r;
        retry_next  = retry_r;
        hp_next     = 1'b0;
        fail_s      = 1'b0;
        load_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!armed_r) begin
                    load_s = 1'b1;
                end else if (expired_s) begin
                    state_next = ST_SEND;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SEND: state_next = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (tx_done) begin
                    state_next = ST_WAIT_RSP;
                end else if (expired_s) begin
                    fail_s = 1'b1;
                end else begin
                    state_next = ST_WAIT_TX;
                end
            end
            ST_WAIT_RSP: begin
                // A byte arriving on the expiry cycle is still honoured.
                if (rx_done) begin
                    if (rx_data == exp_s) begin
                        if ((idx_r + 2'd1) == rsp_len_s) begin
                            idx_next    = 2'd0;
                            resend_next = 2'd0;
                            step_next   = step_r + 3'd1;
                            state_next  = (step_r == 3'd3) ? ST_STREAM : ST_SEND;
                        end else begin
                            idx_next = idx_r + 2'd1;
                        end
                    end else if (rx_data == RSP_RESEND) begin
                        if (resend_r == 2'd2) begin
                            fail_s = 1'b1;
                        end else begin
                            resend_next = resend_r + 2'd1;
                            idx_next    = 2'd0;
                            state_next  = ST_SEND;
                        end
                    end else begin
                        fail_s = 1'b1;
                    end
                end else if (expired_s) begin
                    fail_s = 1'b1;
                end else begin
                    state_next = ST_WAIT_RSP;
                end
            end
            ST_STREAM: begin
                // AA then 00 back to back means the mouse was replugged.
                if (rx_done) begin
                    if (hp_r && (rx_data == RSP_ID)) begin
                        retry_next = 2'd0;
                        step_next  = 3'd0;
                        idx_next   = 2'd0;
                        state_next = ST_SEND;
                    end else begin
                        hp_next = (rx_data == RSP_BAT_OK);
                    end
                end else begin
                    hp_next = hp_r;
                end
            end
            ST_FAIL: state_next = ST_FAIL;
            default: state_next = ST_IDLE;
        endcase

        if (fail_s) begin
            step_next   = 3'd0;
            idx_next    = 2'd0;
            resend_next = 2'd0;
            if (retry_r < MAX_RETRY_C) begin
                retry_next = retry_r + 2'd1;
                state_next = ST_SEND;
            end else begin
                state_next = ST_FAIL;
            end
        end else begin
            retry_next = retry_next;
        end

        if (restart) begin
            retry_next  = 2'd0;
            step_next   = 3'd0;
            idx_next    = 2'd0;
            resend_next = 2'd0;
            hp_next     = 1'b0;
            state_next  = ST_SEND;
        end else begin
            hp_next = hp_next;
        end

        // Reload on every state entry and on each accepted reply byte.
        if ((state_next != state_r) || (idx_next != idx_r)) begin
            load_s = 1'b1;
        end else begin
            load_s = load_s;
        end
    end

    // Window selection: the BAT result (0xAA) wait gets the long window.
    always_comb begin
        if (state_next == ST_IDLE) begin
            load_val_s = PWRUP_CYC;
        end else if ((state_next == ST_WAIT_RSP) && (step_next == 3'd0) && (idx_next == 2'd1)) begin
            load_val_s = BAT_CYC;
        end else begin
            load_val_s = TIMEOUT_CYC;
        end
    end

    // Sequencer state and registered outputs; status decodes track next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            step_r     <= 3'd0;
            idx_r      <= 2'd0;
            resend_r   <= 2'd0;
            retry_r    <= 2'd0;
            hp_r       <= 1'b0;
            armed_r    <= 1'b0;
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
            stream_r   <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            led_r      <= 3'd0;
        end else begin
            state_r    <= state_next;
            step_r     <= step_next;
            idx_r      <= idx_next;
            resend_r   <= resend_next;
            retry_r    <= retry_next;
            hp_r       <= hp_next;
            armed_r    <= 1'b1;
            tx_start_r <= (state_r == ST_SEND);
            tx_data_r  <= (state_r == ST_SEND) ? cmd_s : tx_data_r;
            stream_r   <= (state_next == ST_STREAM);
            done_r     <= (state_next == ST_STREAM);
            err_r      <= (state_next == ST_FAIL);
            led_r      <= state_next;
        end
    end

    // restart must close the gate in the very cycle it is seen.
    assign stream_en  = stream_r & ~restart;
    assign tx_start   = tx_start_r;
    assign tx_data    = tx_data_r;
    assign init_done  = done_r;
    assign init_error = err_r;
    assign retry_cnt  = retry_r;
    assign led_state  = led_r;

endmodule

// File: tb/tb_ps2_mouse_init.sv
// Self-checking bench for ps2_mouse_init: a device model answers commands,
// expected command bytes are queued and compared as tx_start appears.
module tb_ps2_mouse_init;

    localparam int CLK_HZ    = 10_000;
    localparam int PWRUP_MS  = 20;
    localparam int TO_MS     = 5;
    localparam int BAT_MS    = 30;
    localparam int PWRUP_CYC = 200;
    localparam int BAT_CYC   = 300;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       restart = 1'b0;
    logic       tx_done = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       stream_en, init_done, init_error;
    logic [1:0] retry_cnt;
    logic [2:0] led_state;

    logic [7:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ps2_mouse_init #(
        .CLK_HZ         (CLK_HZ),
        .PWRUP_MS       (PWRUP_MS),
        .TIMEOUT_MS     (TO_MS),
        .BAT_TIMEOUT_MS (BAT_MS),
        .MAX_RETRY      (3),
        .SAMPLE_RATE    (8'd100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .restart    (restart),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .rx_done    (rx_done),
        .rx_data    (rx_data),
        .stream_en  (stream_en),
        .init_done  (init_done),
        .init_error (init_error),
        .retry_cnt  (retry_cnt),
        .led_state  (led_state)
    );

    task automatic send_rx(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_tx(input int budget, input bit ack, output logic [7:0] b,
                           output bit ok, output int waited);
        ok = 1'b0;
        b = 8'h00;
        waited = 0;
        while (!ok && waited < budget) begin
            @(negedge clk);
            waited++;
            if (tx_start) begin
                ok = 1'b1;
                b = tx_data;
            end
        end
        if (ok && ack) begin
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    endtask

    task automatic answer_step(input int s);
        if (s == 0) begin
            send_rx(8'hFA);
            send_rx(8'hAA);
            send_rx(8'h00);
        end else begin
            send_rx(8'hFA);
        end
    endtask

    task automatic finish_script(input int from_step);
        logic [7:0] b;
        bit ok;
        int w;
        for (int s = from_step; s < 4; s++) begin
            wait_tx(60, 1'b1, b, ok, w);
            answer_step(s);
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tx_start, tx_data, stream_en, init_done, init_error, retry_cnt, led_state} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {tx_start, tx_data, stream_en, init_done, init_error, retry_cnt, led_state});
        end
        reset = 1'b1;
    endtask

    task automatic test_clean_init();
        logic [7:0] got, exp_b;
        bit ok;
        int w;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hF3);
        exp_q.push_back(8'h64);
        exp_q.push_back(8'hF4);
        for (int s = 0; s < 4; s++) begin
            wait_tx((s == 0) ? PWRUP_CYC + 60 : 60, 1'b1, got, ok, w);
            exp_b = exp_q.pop_front();
            n_cmp++;
            if (!ok || got !== exp_b) begin
                n_bad++;
                $display("FAIL clean_cmd%0d: got %h (seen=%0d), want %h", s, got, ok, exp_b);
            end
            if (s == 0) begin
                n_cmp++;
                if (w < PWRUP_CYC || w > PWRUP_CYC + 6) begin
                    n_bad++;
                    $display("FAIL pwrup_wait: got %0d cycles, want %0d..%0d", w, PWRUP_CYC, PWRUP_CYC + 6);
                end
            end
            if (s < 3) answer_step(s);
        end
        rx_data = 8'hFA;
        rx_done = 1'b1;
        #1;
        n_cmp++;
        if (stream_en !== 1'b0) begin
            n_bad++;
            $display("FAIL stream_early: got %b, want 0", stream_en);
        end
        @(negedge clk);
        rx_done = 1'b0;
        n_cmp++;
        if ({stream_en, init_done, retry_cnt, led_state} !== {1'b1, 1'b1, 2'd0, 3'd4}) begin
            n_bad++;
            $display("FAIL clean_stream: got en=%b done=%b retry=%0d led=%0d, want 1 1 0 4",
                     stream_en, init_done, retry_cnt, led_state);
        end
    endtask

    task automatic test_restart_resend();
        logic [7:0] got, exp_b;
        bit ok;
        int w;
        restart = 1'b1;
        #1;
        n_cmp++;
        if (stream_en !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_gate: got stream_en %b, want 0", stream_en);
        end
        @(negedge clk);
        restart = 1'b0;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hF3);
        exp_q.push_back(8'hF3);
        exp_q.push_back(8'h64);
        exp_q.push_back(8'hF4);
        for (int k = 0; k < 5; k++) begin
            wait_tx(60, 1'b1, got, ok, w);
            exp_b = exp_q.pop_front();
            n_cmp++;
            if (!ok || got !== exp_b) begin
                n_bad++;
                $display("FAIL resend_cmd%0d: got %h (seen=%0d), want %h", k, got, ok, exp_b);
            end
            if (k == 0) answer_step(0);
            else if (k == 1) send_rx(8'hFE);
            else send_rx(8'hFA);
        end
        n_cmp++;
        if ({init_done, retry_cnt, exp_q.size() == 0} !== {1'b1, 2'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL resend_done: got done=%b retry=%0d left=%0d, want 1 0 0",
                     init_done, retry_cnt, exp_q.size());
        end
    endtask

    task automatic test_resend_limit_bat_fail();
        logic [7:0] got, exp_b;
        bit ok;
        int w;
        pulse_restart();
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hF3);
        exp_q.push_back(8'hF3);
        exp_q.push_back(8'hF3);
        exp_q.push_back(8'hFF);
        for (int k = 0; k < 5; k++) begin
            wait_tx(60, 1'b1, got, ok, w);
            exp_b = exp_q.pop_front();
            n_cmp++;
            if (!ok || got !== exp_b) begin
                n_bad++;
                $display("FAIL limit_cmd%0d: got %h (seen=%0d), want %h", k, got, ok, exp_b);
            end
            if (k == 0) answer_step(0);
            else if (k < 4) send_rx(8'hFE);
        end
        n_cmp++;
        if (retry_cnt !== 2'd1) begin
            n_bad++;
            $display("FAIL limit_retry: got %0d, want 1", retry_cnt);
        end
        send_rx(8'hFA);
        send_rx(8'hFC);
        exp_q.push_back(8'hFF);
        wait_tx(8, 1'b1, got, ok, w);
        exp_b = exp_q.pop_front();
        n_cmp++;
        if (!ok || got !== exp_b || w != 1) begin
            n_bad++;
            $display("FAIL bat_restart: got %h after %0d cycles (seen=%0d), want %h after 1", got, w, ok, exp_b);
        end
        n_cmp++;
        if (retry_cnt !== 2'd2) begin
            n_bad++;
            $display("FAIL bat_retry: got %0d, want 2", retry_cnt);
        end
        answer_step(0);
        finish_script(1);
        n_cmp++;
        if ({init_done, retry_cnt} !== {1'b1, 2'd2}) begin
            n_bad++;
            $display("FAIL bat_stream: got done=%b retry=%0d, want 1 2", init_done, retry_cnt);
        end
    endtask

    task automatic test_hotplug();
        logic [7:0] got, exp_b;
        bit ok;
        int w;
        send_rx(8'h00);
        wait_tx(20, 1'b0, got, ok, w);
        n_cmp++;
        if (ok || init_done !== 1'b1) begin
            n_bad++;
            $display("FAIL lone_id: got tx=%0d done=%b, want 0 1", ok, init_done);
        end
        send_rx(8'hAA);
        send_rx(8'h00);
        n_cmp++;
        if ({retry_cnt, stream_en} !== {2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL hotplug_clear: got retry=%0d en=%b, want 0 0", retry_cnt, stream_en);
        end
        exp_q.push_back(8'hFF);
        wait_tx(8, 1'b1, got, ok, w);
        exp_b = exp_q.pop_front();
        n_cmp++;
        if (!ok || got !== exp_b) begin
            n_bad++;
            $display("FAIL hotplug_cmd: got %h (seen=%0d), want %h", got, ok, exp_b);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] got, exp_b;
        bit ok;
        int w;
        for (int f = 0; f < 4; f++) begin
            send_rx(8'hFA);
            if (f < 3) begin
                exp_q.push_back(8'hFF);
                wait_tx(BAT_CYC + 60, 1'b1, got, ok, w);
                exp_b = exp_q.pop_front();
                n_cmp++;
                if (!ok || got !== exp_b || w < BAT_CYC - 5 || w > BAT_CYC + 10) begin
                    n_bad++;
                    $display("FAIL timeout_cmd%0d: got %h after %0d cycles (seen=%0d), want %h after ~%0d",
                             f, got, w, ok, exp_b, BAT_CYC);
                end
                n_cmp++;
                if (retry_cnt !== 2'(f + 1)) begin
                    n_bad++;
                    $display("FAIL timeout_retry%0d: got %0d, want %0d", f, retry_cnt, f + 1);
                end
            end else begin
                wait_tx(BAT_CYC + 200, 1'b0, got, ok, w);
                n_cmp++;
                if (ok) begin
                    n_bad++;
                    $display("FAIL fail_silent: got tx_start with %h, want none", got);
                end
                n_cmp++;
                if ({init_error, led_state, init_done, retry_cnt} !== {1'b1, 3'd5, 1'b0, 2'd3}) begin
                    n_bad++;
                    $display("FAIL fail_state: got err=%b led=%0d done=%b retry=%0d, want 1 5 0 3",
                             init_error, led_state, init_done, retry_cnt);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] got, exp_b;
        bit ok;
        int w;
        pulse_restart();
        exp_q.push_back(8'hFF);
        wait_tx(8, 1'b0, got, ok, w);
        exp_b = exp_q.pop_front();
        n_cmp++;
        if (!ok || got !== exp_b || init_error !== 1'b0) begin
            n_bad++;
            $display("FAIL fail_restart: got %h (seen=%0d) err=%b, want %h err 0", got, ok, init_error, exp_b);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({tx_start, tx_data, stream_en, init_done, init_error, retry_cnt, led_state} !== 17'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %b, want all zero",
                     {tx_start, tx_data, stream_en, init_done, init_error, retry_cnt, led_state});
        end
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(8'hFF);
        wait_tx(PWRUP_CYC + 60, 1'b1, got, ok, w);
        exp_b = exp_q.pop_front();
        n_cmp++;
        if (!ok || got !== exp_b || w < PWRUP_CYC) begin
            n_bad++;
            $display("FAIL reset_pwrup: got %h after %0d cycles (seen=%0d), want %h after >=%0d",
                     got, w, ok, exp_b, PWRUP_CYC);
        end
    endtask

    initial begin
        test_reset();
        test_clean_init();
        test_restart_resend();
        test_resend_limit_bat_fail();
        test_hotplug();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
